// File: rtl/genius_core_param.sv
// Parametrised Simon/Genius core: LFSR-generated pattern, timed one-hot LED playback, press checking.
// Optional WAIT_IN press timeout is compiled in when TIMEOUT_EN is defined.
module genius_core_param #(
  parameter int NUM_BTNS       = 4,
  parameter int MAX_LEVEL      = 15,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000,
  localparam int NW            = $clog2(NUM_BTNS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BTNS-1:0] btn,
  input  logic [7:0]          sw,
  output logic [NUM_BTNS-1:0] leds,
  output logic [2:0]          State,
  output logic [3:0]          Current_level,
  output logic [3:0]          Sequence_count,
  output logic [NW-1:0]       Current_number,
  output logic                win,
  output logic                lose
);

  localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES)
                      ? ((SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES)
                      : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
  localparam int TW = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          level_q, level_d;
  logic [3:0]          seq_q, seq_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic                start_r_q, start_r_d, start_p_q, start_p_d;
  logic [NUM_BTNS-1:0] btn_r_q, btn_r_d, btn_p_q, btn_p_d;
  logic [TW-1:0]       timer_q, timer_d;
  // Sized to the full 4-bit level range; only entries below MAX_LEVEL are ever written.
  logic [NW-1:0]       mem_q [16];
  logic [NW-1:0]       mem_d [16];

  logic                start_edge;
  logic [NUM_BTNS-1:0] btn_edge;
  logic [NUM_BTNS-1:0] exp_onehot;
  logic [NW-1:0]       rnd;
  logic [NW-1:0]       cur_num;
  logic                last_step;

  assign start_edge = start_r_q & ~start_p_q;
  assign btn_edge   = btn_r_q & ~btn_p_q;
  assign cur_num    = mem_q[seq_q];
  assign exp_onehot = NUM_BTNS'(1) << cur_num;
  assign rnd        = NW'(lfsr_q % 8'(NUM_BTNS));
  assign last_step  = (seq_q == level_q - 4'd1);

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    seq_d     = seq_q;
    timer_d   = timer_q;
    mem_d     = mem_q;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    start_r_d = start;
    start_p_d = start_r_q;
    btn_r_d   = btn;
    btn_p_d   = btn_r_q;

    // A start edge wins over everything else, from any state.
    if (start_edge) begin
      lfsr_d  = (sw == 8'h00) ? 8'hA5 : sw;
      level_d = 4'd0;
      seq_d   = 4'd0;
      state_d = S_GEN;
    end else begin
      case (state_q)
        S_GEN: begin
          mem_d[level_q] = rnd;
          level_d        = level_q + 4'd1;
          seq_d          = 4'd0;
          state_d        = S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (timer_q == TW'(SHOW_CYCLES - 1)) state_d = S_SHOW_OFF;
          else                                  timer_d = timer_q + TW'(1);
        end
        S_SHOW_OFF: begin
          if (timer_q == TW'(GAP_CYCLES - 1)) begin
            if (last_step) begin
              seq_d   = 4'd0;
              state_d = S_WAIT_IN;
            end else begin
              seq_d   = seq_q + 4'd1;
              state_d = S_SHOW_ON;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_WAIT_IN: begin
          // An exact match with the one-hot target also implies a single edge.
          if (btn_edge == exp_onehot) begin
            timer_d = '0;
            if (last_step) state_d = (level_q == 4'(MAX_LEVEL)) ? S_WIN : S_GEN;
            else           seq_d   = seq_q + 4'd1;
          end else if (btn_edge != '0) begin
            state_d = S_LOSE;
          end
`ifdef TIMEOUT_EN
          else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_LOSE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
`endif
        end
        default: ;
      endcase
    end

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      level_q   <= 4'd0;
      seq_q     <= 4'd0;
      lfsr_q    <= 8'hA5;
      start_r_q <= 1'b0;
      start_p_q <= 1'b0;
      btn_r_q   <= '0;
      btn_p_q   <= '0;
      timer_q   <= '0;
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      seq_q     <= seq_d;
      lfsr_q    <= lfsr_d;
      start_r_q <= start_r_d;
      start_p_q <= start_p_d;
      btn_r_q   <= btn_r_d;
      btn_p_q   <= btn_p_d;
      timer_q   <= timer_d;
      mem_q     <= mem_d;
    end
  end

  always_comb begin
    leds = '0;
    win  = 1'b0;
    lose = 1'b0;
    case (state_q)
      S_SHOW_ON: leds = exp_onehot;
      S_WAIT_IN: leds = btn_r_q;
      S_WIN: begin
        win  = 1'b1;
        leds = '1;
      end
      S_LOSE:    lose = 1'b1;
      default: ;
    endcase
  end

  assign State          = state_q;
  assign Current_level  = level_q;
  assign Sequence_count = seq_q;
  assign Current_number = (state_q == S_IDLE) ? '0 : cur_num;

endmodule

// File: tb/tb_genius_core_param.sv
// Bench for genius_core_param: directed vector table for the first rounds, then game-level sequences.
module tb_genius_core_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] btn;
  logic [7:0] sw;
  logic [3:0] leds;
  logic [2:0] State;
  logic [3:0] Current_level;
  logic [3:0] Sequence_count;
  logic [1:0] Current_number;
  logic       win;
  logic       lose;

  int checks = 0;
  int failures = 0;

  logic [3:0] rec [16];
  int         rec_n;

  genius_core_param #(
    .NUM_BTNS(4), .MAX_LEVEL(3), .SHOW_CYCLES(2), .GAP_CYCLES(1), .TIMEOUT_CYCLES(10)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .btn(btn), .sw(sw),
    .leds(leds), .State(State), .Current_level(Current_level),
    .Sequence_count(Sequence_count), .Current_number(Current_number),
    .win(win), .lose(lose)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic [3:0] b;
    logic [2:0] e_state;
    logic [3:0] e_leds;
    logic [3:0] e_lvl;
    logic [3:0] e_seq;
  } vec_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic restart();
    btn   = 4'h0;
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    step();
    chk("restart_state", State, 3'd1);
    chk("restart_level", Current_level, 4'd0);
  endtask

  // Follows playback into WAIT_IN, recording each step's LEDs and checking on/gap lengths.
  task automatic run_playback(input int lvl);
    int cyc = 0;
    int on_len = 0;
    int off_len = 0;
    logic [2:0] prev = 3'd7;
    rec_n = 0;
    while (State != 3'd4 && cyc < 200) begin
      if (State == 3'd2 && prev != 3'd2) begin
        if (rec_n < 16) rec[rec_n] = leds;
        chk("pb_onehot", 32'($onehot(leds)), 32'd1);
        rec_n++;
        on_len = 0;
      end
      if (State == 3'd3 && prev != 3'd3) off_len = 0;
      if (State == 3'd2) on_len++;
      if (State == 3'd3) off_len++;
      if (prev == 3'd2 && State == 3'd3) chk("pb_on_len", on_len, 2);
      if (prev == 3'd3 && State == 3'd2) chk("pb_off_len", off_len, 1);
      prev = State;
      step();
      cyc++;
    end
    if (prev == 3'd3) chk("pb_off_len", off_len, 1);
    chk("pb_reach_wait_in", State, 3'd4);
    chk("pb_steps", rec_n, lvl);
    chk("pb_level", Current_level, lvl);
  endtask

  task automatic replay();
    for (int i = 0; i < rec_n; i++) begin
      chk("rp_seq", Sequence_count, i);
      chk("rp_number", 4'(1) << Current_number, rec[i]);
      btn = rec[i];
      step();
      chk("rp_echo", leds, rec[i]);
      step();
      btn = 4'h0;
      step();
    end
  endtask

  initial begin
    vec_t tv [12];
    logic [3:0] wrong;
    int n;

    tv[0]  = '{1'b0, 4'h0, 3'd0, 4'h0, 4'd0, 4'd0};
    tv[1]  = '{1'b1, 4'h0, 3'd0, 4'h0, 4'd0, 4'd0};
    tv[2]  = '{1'b1, 4'h0, 3'd1, 4'h0, 4'd0, 4'd0};
    tv[3]  = '{1'b1, 4'h0, 3'd2, 4'h2, 4'd1, 4'd0};
    tv[4]  = '{1'b0, 4'h0, 3'd2, 4'h2, 4'd1, 4'd0};
    tv[5]  = '{1'b0, 4'h0, 3'd3, 4'h0, 4'd1, 4'd0};
    tv[6]  = '{1'b0, 4'h0, 3'd4, 4'h0, 4'd1, 4'd0};
    tv[7]  = '{1'b0, 4'h2, 3'd4, 4'h2, 4'd1, 4'd0};
    tv[8]  = '{1'b0, 4'h2, 3'd1, 4'h0, 4'd1, 4'd0};
    tv[9]  = '{1'b0, 4'h0, 3'd2, 4'h2, 4'd2, 4'd0};
    tv[10] = '{1'b0, 4'h0, 3'd2, 4'h2, 4'd2, 4'd0};
    tv[11] = '{1'b0, 4'h0, 3'd3, 4'h0, 4'd2, 4'd0};

    reset = 1'b0;
    start = 1'b0;
    btn   = 4'h0;
    sw    = 8'h01;
    repeat (3) step();
    chk("rst_state", State, 3'd0);
    chk("rst_leds", leds, 4'h0);
    chk("rst_win", win, 1'b0);
    chk("rst_lose", lose, 1'b0);
    chk("rst_level", Current_level, 4'd0);
    chk("rst_number", Current_number, 2'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      start = tv[i].st;
      btn   = tv[i].b;
      step();
      chk($sformatf("vec%0d_state", i), State, tv[i].e_state);
      chk($sformatf("vec%0d_leds", i), leds, tv[i].e_leds);
      chk($sformatf("vec%0d_level", i), Current_level, tv[i].e_lvl);
      chk($sformatf("vec%0d_seq", i), Sequence_count, tv[i].e_seq);
    end

    // Full game to MAX_LEVEL.
    restart();
    for (int lvl = 1; lvl <= 3; lvl++) begin
      run_playback(lvl);
      replay();
    end
    chk("win_flag", win, 1'b1);
    chk("win_state", State, 3'd5);
    chk("win_leds", leds, 4'hF);
    chk("win_lose", lose, 1'b0);

    restart();
    chk("win_cleared", win, 1'b0);
    run_playback(1);
    chk("new_game_level", Current_level, 4'd1);

    // Wrong single press.
    wrong = {rec[0][2:0], rec[0][3]};
    btn = wrong;
    step();
    chk("wrong_wait", State, 3'd4);
    step();
    chk("wrong_state", State, 3'd6);
    chk("wrong_lose", lose, 1'b1);
    chk("wrong_leds", leds, 4'h0);
    btn = 4'h0;
    step();

    // Two simultaneous edges.
    restart();
    chk("lose_cleared", lose, 1'b0);
    run_playback(1);
    btn = 4'b0011;
    step();
    step();
    chk("multi_state", State, 3'd6);
    btn = 4'h0;
    step();

    // Button held across entry to WAIT_IN must not count.
    restart();
    btn = 4'b0010;
    run_playback(1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_no_accept", State, 3'd4);
    end
    btn = 4'h0;
    step();
    btn = 4'b0010;
    step();
    step();
    chk("fresh_press_gen", State, 3'd1);
    btn = 4'h0;

    // Idle WAIT_IN.
    restart();
    run_playback(1);
`ifdef TIMEOUT_EN
    repeat (9) step();
    chk("timeout_before", State, 3'd4);
    step();
    chk("timeout_state", State, 3'd6);
    chk("timeout_lose", lose, 1'b1);
`else
    repeat (100) step();
    chk("no_timeout_state", State, 3'd4);
`endif

    // Asynchronous reset during playback.
    restart();
    n = 0;
    while (State != 3'd2 && n < 20) begin
      step();
      n++;
    end
    chk("midreset_in_show", State, 3'd2);
    reset = 1'b0;
    #1;
    chk("midreset_state", State, 3'd0);
    chk("midreset_leds", leds, 4'h0);
    chk("midreset_level", Current_level, 4'd0);
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("post_reset_idle", State, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/genius_core_param.md
Name: genius_core_param

Overview:
Parametrised successor to the fixed 3-button Genius (Simon) game core. It supports NUM_BTNS buttons/LEDs and a configurable maximum level. It generates the pattern with an internal LFSR seeded from switches, plays it on one-hot LEDs with programmable on/gap times, then checks player presses. It sits between the board debouncers and the 7-segment/LED display logic, and exports state, level, sequence counter and current number for the display and debug.

Parameters:
NUM_BTNS, 4, number of buttons/LEDs (2..8); number width NW = clog2(NUM_BTNS)
MAX_LEVEL, 15, winning level and sequence memory depth (1..15)
SHOW_CYCLES, 25000000, clock cycles an LED is lit during playback (>=1)
GAP_CYCLES, 12500000, clock cycles all LEDs are dark between playback steps (>=1)
TIMEOUT_CYCLES, 250000000, max cycles allowed between presses (used only with TIMEOUT_EN)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  level signal; its rising edge starts or restarts a game
btn  input  NUM_BTNS  debounced button levels, active-high
sw  input  8  LFSR seed, sampled on the start edge
leds  output  NUM_BTNS  playback/echo LEDs
State  output  3  current FSM state encoding
Current_level  output  4  current level (0..MAX_LEVEL)
Sequence_count  output  4  index of the current playback/input step
Current_number  output  NW  sequence entry at Sequence_count
win  output  1  high while in WIN
lose  output  1  high while in LOSE

Behaviour:
- Reset (reset=0, async): State=IDLE(0); Current_level, Sequence_count, Current_number, leds, win, lose = 0; LFSR = 8'hA5; start/btn edge registers = 0.
- Edge detection: start and btn are registered once. An edge is "prev=0, now=1" on the registered values, so the response comes one clock after sampling.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle. On the start edge it loads sw, or 8'hA5 if sw==0. The new number is lfsr % NUM_BTNS.
- States: IDLE=0, GEN=1, SHOW_ON=2, SHOW_OFF=3, WAIT_IN=4, WIN=5, LOSE=6.
- IDLE: on a start edge, set Current_level=0 and go to GEN.
- GEN (1 cycle): mem[Current_level] <= rnd; Current_level++; Sequence_count=0; go to SHOW_ON.
- SHOW_ON: leds = one-hot(mem[Sequence_count]) for exactly SHOW_CYCLES cycles, then go to SHOW_OFF.
- SHOW_OFF: leds=0 for GAP_CYCLES cycles. Then:
  - if Sequence_count == Current_level-1: Sequence_count=0, go to WAIT_IN;
  - else Sequence_count++, go to SHOW_ON.
- WAIT_IN, leds echo the registered btn levels:
  - exactly one new button edge equal to mem[Sequence_count]:
    - if this is the last step (Sequence_count == Current_level-1): go to WIN if Current_level == MAX_LEVEL, else go to GEN;
    - otherwise Sequence_count++.
  - one wrong edge, or two or more simultaneous edges: go to LOSE.
  - no edge: hold.
- WIN: win=1, leds all 1. LOSE: lose=1, leds=0. Both hold until a start edge, which clears the flags and behaves as the start edge in IDLE.
- A start edge in any non-IDLE state restarts the game: LFSR reseed, Current_level=0, go to GEN.
- Buttons are ignored outside WAIT_IN. A button held across the entry to WAIT_IN does not count; only a fresh edge counts.
- Current_number = mem[Sequence_count], combinational read of registered memory; it is 0 in IDLE.
- Timer counters are width clog2(max(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES))+1 and reload on every state entry.
- Level arithmetic is 4-bit and never exceeds MAX_LEVEL.

Optional Feature:
TIMEOUT_EN
- Defined: in WAIT_IN a counter reloads on entry and after every accepted press. Reaching TIMEOUT_CYCLES with no press forces LOSE.
- Undefined: WAIT_IN waits indefinitely, and the counter logic is not synthesised.

Test Plan:
1. Reset check: hold reset=0 for 3 cycles, then release -> State=0, leds=0, win=0, lose=0, Current_level=0.
2. First round (NUM_BTNS=4, MAX_LEVEL=3, SHOW_CYCLES=2, GAP_CYCLES=1, sw=8'h01): start edge -> State reaches 2 within 3 cycles; leds is one-hot for exactly 2 cycles, then 0 for 1 cycle; State=4.
3. Full win: the bench records the playback LEDs and replays them as presses for levels 1..3 -> win=1, State=5, leds=4'hF. A new start edge clears win and gives Current_level=1.
4. Wrong press: press a button different from Current_number in WAIT_IN -> lose=1, State=6 two cycles after the btn rise.
5. Multi-press and mid-game reset: rise btn=4'b0011 simultaneously in WAIT_IN -> LOSE. A separate run asserts reset=0 during SHOW_ON -> immediately State=0, leds=0.
6. Timeout (TIMEOUT_EN, TIMEOUT_CYCLES=10): enter WAIT_IN with no press -> lose=1 after 10 cycles. Without the macro -> State stays 4 after 100 cycles.
